// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan-bus capture path.
package led_matrix_pkg;

   localparam int unsigned MATRIX_DIM = 8;
   // Frame bit for pixel (r,c) is c + PIX_ROW_STRIDE*r.
   localparam int unsigned PIX_ROW_STRIDE = MATRIX_DIM;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StDwell  = 2'd2
   } cap_state_e;

   function automatic logic [5:0] pix_idx(input logic [2:0] col, input logic [2:0] row);
      return 6'(PIX_ROW_STRIDE * row + col);
   endfunction

endpackage

// File: rtl/led_colm_decode.sv
// Column-strobe decoder: classifies a column code as valid (one-hot), blank or illegal.
module led_colm_decode
   import led_matrix_pkg::*;
(
   input  logic [7:0] colms_i,
   input  logic       an_i,
   output logic       valid_o,
   output logic       blank_o,
   output logic       illegal_o,
   output logic [2:0] index_o
);

   logic [7:0] act;
   logic       single;

   assign act       = ~(colms_i ^ {8{an_i}});
   assign blank_o   = (act == 8'h00);
   assign single    = ((act & (act - 8'd1)) == 8'h00);
   assign valid_o   = ~blank_o & single;
   assign illegal_o = ~blank_o & ~single;

   // Strobe bit i maps to column 7-i.
   always_comb begin
      index_o = 3'd0;
      for (int i = 0; i < MATRIX_DIM; i++) begin
         if (act[i]) begin
            index_o = 3'(MATRIX_DIM - 1 - i);
         end
      end
   end

endmodule

// File: rtl/led_matrix_capture8x8.sv
// Reconstructs the displayed 64-bit frame from the rows/colms scan bus.
// Optional sticky illegal-strobe flag err_o is built when LED_CAPTURE_ERR_EN is defined.
module led_matrix_capture8x8
   import led_matrix_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        an_i,
   input  logic [7:0]  colms_i,
   input  logic [7:0]  rows_i,
   output logic [63:0] array_o,
   output logic        frame_valid_o,
   output logic [7:0]  seen_o
`ifdef LED_CAPTURE_ERR_EN
   ,
   output logic        err_o
`endif
);

   localparam logic [3:0] SettleCnt = 4'(SETTLE);
   localparam bit         SettleOne = (SETTLE <= 1);

   logic [7:0]  colms_q, rows_q;
   logic        an_q;

   cap_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d, cnt_inc;
   logic [2:0]  col_q, col_d;
   logic        sample;

   logic [63:0] shadow_q, shadow_d;
   logic [63:0] array_q, array_d;
   logic [7:0]  seen_q, seen_d;
   logic        done_q, done_d;
   logic        fv_q, fv_d;
   logic [7:0]  lit;

   logic        dec_valid, dec_blank, dec_illegal;
   logic [2:0]  dec_index;

   led_colm_decode u_decode (
      .colms_i   (colms_q),
      .an_i      (an_q),
      .valid_o   (dec_valid),
      .blank_o   (dec_blank),
      .illegal_o (dec_illegal),
      .index_o   (dec_index)
   );

   assign lit = rows_q ^ {8{an_q}};

   // Column tracking and stability counting; sample marks the edge that captures rows.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      sample  = 1'b0;
      cnt_inc = cnt_q + 4'd1;
      unique case (state_q)
         StIdle: begin
            if (dec_valid) begin
               col_d = dec_index;
               cnt_d = 4'd1;
               if (SettleOne) begin
                  sample  = 1'b1;
                  state_d = StDwell;
               end else begin
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (dec_blank || dec_illegal) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (dec_index != col_q) begin
               col_d = dec_index;
               cnt_d = 4'd1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= SettleCnt) begin
                  sample  = 1'b1;
                  state_d = StDwell;
               end
            end
         end
         StDwell: begin
            if (dec_blank || dec_illegal) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (dec_index != col_q) begin
               col_d = dec_index;
               cnt_d = 4'd1;
               if (SettleOne) begin
                  sample = 1'b1;
               end else begin
                  state_d = StSettle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
      if (!en_i) begin
         state_d = StIdle;
         cnt_d   = 4'd0;
         sample  = 1'b0;
      end
   end

   // Completion clears seen first so a sample on the same edge starts the next frame.
   always_comb begin
      seen_d   = done_q ? 8'h00 : seen_q;
      shadow_d = shadow_q;
      if (sample) begin
         seen_d[col_d] = 1'b1;
         for (int r = 0; r < MATRIX_DIM; r++) begin
            shadow_d[pix_idx(col_d, 3'(r))] = lit[r];
         end
      end
      done_d  = sample & (&seen_d);
      array_d = done_q ? shadow_q : array_q;
      fv_d    = done_q;
      if (!en_i) begin
         seen_d  = 8'h00;
         done_d  = 1'b0;
         fv_d    = 1'b0;
         array_d = array_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         colms_q  <= 8'h00;
         rows_q   <= 8'h00;
         an_q     <= 1'b0;
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         col_q    <= 3'd0;
         shadow_q <= 64'h0;
         array_q  <= 64'h0;
         seen_q   <= 8'h00;
         done_q   <= 1'b0;
         fv_q     <= 1'b0;
      end else begin
         colms_q  <= colms_i;
         rows_q   <= rows_i;
         an_q     <= an_i;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         col_q    <= col_d;
         shadow_q <= shadow_d;
         array_q  <= array_d;
         seen_q   <= seen_d;
         done_q   <= done_d;
         fv_q     <= fv_d;
      end
   end

   assign array_o       = array_q;
   assign frame_valid_o = fv_q;
   assign seen_o        = seen_q;

`ifdef LED_CAPTURE_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q | (en_i & dec_illegal);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_led_matrix_capture8x8.sv
// Scoreboard bench for led_matrix_capture8x8 (SETTLE=1 and SETTLE=3 instances).
// err_o checks are compiled in when LED_CAPTURE_ERR_EN is defined.
module tb_led_matrix_capture8x8;

   logic        clk, rst, en1, en3, an;
   logic [7:0]  colms, rows;
   logic [63:0] arr1, arr3;
   logic        fv1, fv3;
   logic [7:0]  seen1, seen3;
`ifdef LED_CAPTURE_ERR_EN
   logic        err1, err3;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [63:0] exp1_q[$];
   logic [63:0] exp3_q[$];
   int          fv1_q[$];
   int          fv3_q[$];
   logic [7:0]  prev_seen1, prev_seen3;
   logic [63:0] last1;

   localparam logic [63:0] Img1 = 64'h0018242424241800;
   localparam logic [63:0] Img2 = 64'h8142_2418_1824_4281;
   localparam logic [63:0] Img3 = 64'hF0F0_0F0F_AA55_33CC;
   localparam logic [63:0] Img4 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] Img5 = 64'hFEDC_BA98_7654_3210;

   led_matrix_capture8x8 #(.SETTLE(1)) dut1 (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en1),
      .an_i          (an),
      .colms_i       (colms),
      .rows_i        (rows),
      .array_o       (arr1),
      .frame_valid_o (fv1),
      .seen_o        (seen1)
`ifdef LED_CAPTURE_ERR_EN
      ,
      .err_o         (err1)
`endif
   );

   led_matrix_capture8x8 #(.SETTLE(3)) dut3 (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en3),
      .an_i          (an),
      .colms_i       (colms),
      .rows_i        (rows),
      .array_o       (arr3),
      .frame_valid_o (fv3),
      .seen_o        (seen3)
`ifdef LED_CAPTURE_ERR_EN
      ,
      .err_o         (err3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pops the expected frame whenever a DUT publishes one.
   always @(negedge clk) begin
      if (!rst && fv1) begin
         fv1_q.push_back(cyc);
         checks++;
         if (exp1_q.size() == 0) begin
            failures++;
            $display("FAIL dut1_frame unexpected frame_valid array=%h", arr1);
         end else begin
            logic [63:0] e;
            e = exp1_q.pop_front();
            if (arr1 !== e) begin
               failures++;
               $display("FAIL dut1_frame array=%h required=%h", arr1, e);
            end
         end
         checks++;
         if (prev_seen1 !== 8'hFF) begin
            failures++;
            $display("FAIL dut1_seen_before_fv seen=%h required=ff", prev_seen1);
         end
      end
      if (!rst && fv3) begin
         fv3_q.push_back(cyc);
         checks++;
         if (exp3_q.size() == 0) begin
            failures++;
            $display("FAIL dut3_frame unexpected frame_valid array=%h", arr3);
         end else begin
            logic [63:0] e;
            e = exp3_q.pop_front();
            if (arr3 !== e) begin
               failures++;
               $display("FAIL dut3_frame array=%h required=%h", arr3, e);
            end
         end
      end
      prev_seen1 = seen1;
      prev_seen3 = seen3;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_blank();
      colms = {8{~an}};
      rows  = {8{an}};
   endtask

   // Mirrors the column-scan driver: strobe column c, rows carry that column's pixels.
   task automatic drive_col(input int c, input logic [63:0] img);
      colms = {8{~an}};
      colms[7-c] = an;
      for (int r = 0; r < 8; r++) rows[r] = an ^ img[c + 8*r];
   endtask

   task automatic do_reset();
      set_blank();
      rst = 1'b1;
      en1 = 1'b0;
      en3 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      en1 = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp1_q.size() != 0 || exp3_q.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d required=0", name, exp1_q.size() + exp3_q.size());
         exp1_q.delete();
         exp3_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (arr1 !== 64'h0) begin
         failures++; $display("FAIL reset_array1 value=%h required=0", arr1);
      end
      checks++;
      if (fv1 !== 1'b0) begin
         failures++; $display("FAIL reset_fv1 value=%b required=0", fv1);
      end
      checks++;
      if (seen1 !== 8'h00) begin
         failures++; $display("FAIL reset_seen1 value=%h required=00", seen1);
      end
      checks++;
      if (arr3 !== 64'h0 || seen3 !== 8'h00 || fv3 !== 1'b0) begin
         failures++; $display("FAIL reset_dut3 array=%h seen=%h fv=%b required=0", arr3, seen3, fv3);
      end
`ifdef LED_CAPTURE_ERR_EN
      checks++;
      if (err1 !== 1'b0 || err3 !== 1'b0) begin
         failures++; $display("FAIL reset_err err1=%b err3=%b required=0", err1, err3);
      end
`endif
   endtask

   task automatic test_loopback(input logic pol, input string name);
      int t0;
      an = pol;
      set_blank();
      tick();
      tick();
      tick();
      fv1_q.delete();
      t0 = cyc;
      for (int f = 0; f < 3; f++) begin
         exp1_q.push_back(Img1);
         for (int c = 0; c < 8; c++) begin
            drive_col(c, Img1);
            tick();
         end
      end
      set_blank();
      wait_drain(name);
      last1 = Img1;
      checks++;
      if (fv1_q.size() != 3) begin
         failures++; $display("FAIL %s_fv_count value=%0d required=3", name, fv1_q.size());
      end
      for (int i = 0; i < fv1_q.size(); i++) begin
         checks++;
         if (fv1_q[i] != t0 + 10 + 8*i) begin
            failures++;
            $display("FAIL %s_fv_time frame=%0d offset=%0d required=%0d", name, i, fv1_q[i] - t0,
                     10 + 8*i);
         end
      end
   endtask

   task automatic test_settle();
      en1 = 1'b0;
      en3 = 1'b1;
      an  = 1'b1;
      set_blank();
      tick();
      tick();
      fv3_q.delete();
      for (int c = 0; c < 8; c++) begin
         for (int h = 0; h < ((c == 5) ? 2 : 3); h++) begin
            drive_col(c, Img2);
            tick();
         end
      end
      set_blank();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (seen3 !== 8'hDF) begin
         failures++; $display("FAIL settle_short_seen value=%h required=df", seen3);
      end
      checks++;
      if (arr3 !== 64'h0 || fv3_q.size() != 0) begin
         failures++; $display("FAIL settle_no_frame array=%h frames=%0d required=0", arr3, fv3_q.size());
      end
      exp3_q.push_back(Img2);
      for (int h = 0; h < 3; h++) begin
         drive_col(5, Img2);
         tick();
      end
      set_blank();
      wait_drain("settle");
      checks++;
      if (fv3_q.size() != 1 || seen3 !== 8'h00) begin
         failures++;
         $display("FAIL settle_complete frames=%0d seen=%h required=1,00", fv3_q.size(), seen3);
      end
      en3 = 1'b0;
      en1 = 1'b1;
      tick();
   endtask

   task automatic test_illegal();
      an = 1'b1;
      set_blank();
      tick();
      tick();
      fv1_q.delete();
      drive_col(0, Img3);
      tick();
      drive_col(1, Img3);
      tick();
      colms = 8'hC0;
      rows  = 8'h00;
      tick();
      tick();
      set_blank();
      tick();
      tick();
      checks++;
      if (seen1 !== 8'h03) begin
         failures++; $display("FAIL illegal_seen value=%h required=03", seen1);
      end
      checks++;
      if (fv1_q.size() != 0) begin
         failures++; $display("FAIL illegal_no_frame frames=%0d required=0", fv1_q.size());
      end
`ifdef LED_CAPTURE_ERR_EN
      checks++;
      if (err1 !== 1'b1) begin
         failures++; $display("FAIL illegal_err_set value=%b required=1", err1);
      end
      checks++;
      if (err3 !== 1'b0) begin
         failures++; $display("FAIL illegal_err_gated value=%b required=0", err3);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (err1 !== 1'b1) begin
         failures++; $display("FAIL illegal_err_sticky value=%b required=1", err1);
      end
`endif
   endtask

   task automatic test_enable_drop();
      fv1_q.delete();
      for (int c = 0; c < 4; c++) begin
         drive_col(c, Img3);
         tick();
      end
      en1 = 1'b0;
      for (int c = 4; c < 8; c++) begin
         drive_col(c, Img3);
         tick();
      end
      set_blank();
      tick();
      tick();
      checks++;
      if (seen1 !== 8'h00) begin
         failures++; $display("FAIL endrop_seen value=%h required=00", seen1);
      end
      checks++;
      if (arr1 !== last1) begin
         failures++; $display("FAIL endrop_array value=%h required=%h", arr1, last1);
      end
      checks++;
      if (fv1_q.size() != 0) begin
         failures++; $display("FAIL endrop_no_frame frames=%0d required=0", fv1_q.size());
      end
      en1 = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      int t0;
      fv1_q.delete();
      for (int c = 0; c < 5; c++) begin
         drive_col(c, Img4);
         tick();
      end
      do_reset();
      checks++;
      if (arr1 !== 64'h0 || seen1 !== 8'h00 || fv1 !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_outputs array=%h seen=%h fv=%b required=0", arr1, seen1, fv1);
      end
      checks++;
      if (arr3 !== 64'h0) begin
         failures++; $display("FAIL rstmid_array3 value=%h required=0", arr3);
      end
`ifdef LED_CAPTURE_ERR_EN
      checks++;
      if (err1 !== 1'b0) begin
         failures++; $display("FAIL rstmid_err value=%b required=0", err1);
      end
`endif
      tick();
      t0 = cyc;
      exp1_q.push_back(Img5);
      for (int c = 0; c < 8; c++) begin
         drive_col(c, Img5);
         tick();
      end
      set_blank();
      wait_drain("rstmid");
      checks++;
      if (fv1_q.size() != 1) begin
         failures++; $display("FAIL rstmid_fv_count value=%0d required=1", fv1_q.size());
      end else begin
         checks++;
         if (fv1_q[0] != t0 + 10) begin
            failures++;
            $display("FAIL rstmid_fv_time offset=%0d required=10", fv1_q[0] - t0);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      en1   = 1'b0;
      en3   = 1'b0;
      an    = 1'b1;
      colms = 8'h00;
      rows  = 8'hFF;
      last1 = 64'h0;
      tick();
      test_reset();
      test_loopback(1'b1, "loop_an1");
      test_loopback(1'b0, "loop_an0");
      test_settle();
      test_illegal();
      test_enable_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
